// File: rtl/bumpy_collision_detect_pkg.sv
// Shared constants and types for the Bumpy collision path. The movement
// controller imports the same package, so the edge numbering and the tile
// geometry are defined in one place only.
package bumpy_pkg;

  // Bit positions inside an edge code
  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  // Geometry shared with the movement controller
  localparam int TILE_WIDTH   = 80;
  localparam int BUMPY_OFFSET = 24;

  typedef logic [3:0] edge_code_t;

  // RUN accumulates and publishes. CLEAR holds everything at zero until the
  // next frame boundary after EndGame drops.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } det_state_t;

endpackage

// File: rtl/bumpy_collision_detect_if.sv
// Pixel-rate bundle between the sprite/tile object units and the collision
// detector. The master side drives the drawing requests and the frame
// controls; the slave side is the detector, which returns the frame summary.
interface bumpy_collision_detect_if;
  import bumpy_pkg::*;

  logic        startOfFrame;
  logic        EndGame;
  logic        bumpyDR;
  logic [10:0] bumpyOffsetX;
  logic [10:0] bumpyOffsetY;
  logic        brickDR;
  logic        jumpBrickDR;
  logic        borderDR;
  logic        collision;
  logic        jumpCollision;
  edge_code_t  HitEdgeCode;

  modport master (
    output startOfFrame, EndGame, bumpyDR, bumpyOffsetX, bumpyOffsetY,
           brickDR, jumpBrickDR, borderDR,
    input  collision, jumpCollision, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, EndGame, bumpyDR, bumpyOffsetX, bumpyOffsetY,
           brickDR, jumpBrickDR, borderDR,
    output collision, jumpCollision, HitEdgeCode
  );

endinterface

// File: rtl/bumpy_collision_detect_edge.sv
// Combinational mapping from a pixel offset inside the Bumpy sprite to the
// sprite edge bands that pixel lies in. Corner pixels fall in two bands,
// centre pixels in none. An offset outside the sprite never reports an edge.
module edge_classifier
  import bumpy_pkg::*;
#(
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int EDGE_BAND = 4
) (
  input  logic [10:0] offX_i,
  input  logic [10:0] offY_i,
  output edge_code_t  edge_o
);

  // Band membership, gated by an in-sprite range check
  always_comb begin
    edge_o = '0;
    if ((offX_i < 11'(SPRITE_W)) && (offY_i < 11'(SPRITE_H))) begin
      edge_o[EDGE_BOTTOM] = (offY_i >= 11'(SPRITE_H - EDGE_BAND));
      edge_o[EDGE_RIGHT]  = (offX_i >= 11'(SPRITE_W - EDGE_BAND));
      edge_o[EDGE_TOP]    = (offY_i <  11'(EDGE_BAND));
      edge_o[EDGE_LEFT]   = (offX_i <  11'(EDGE_BAND));
    end
  end

endmodule

// File: rtl/bumpy_collision_detect.sv
// Per-frame collision summary for the Bumpy movement controller. Overlaps of
// the Bumpy sprite with bricks, jump bricks and the border are counted while
// frame N is scanned; at startOfFrame the totals are compared against a
// small noise threshold and published, then held steady for frame N+1.
module bumpy_collision_detect
  import bumpy_pkg::*;
#(
  parameter int SPRITE_W       = 32,
  parameter int SPRITE_H       = 32,
  parameter int EDGE_BAND      = 4,
  parameter int MIN_HIT_PIXELS = 2,
  parameter int CNT_BITS       = 10
) (
  input  logic                     clk,
  input  logic                     resetN,
  bumpy_collision_detect_if.slave  bus
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_THR = CNT_BITS'(MIN_HIT_PIXELS);

  // Counters stick at full scale instead of wrapping, so a long overlap can
  // never roll back under the threshold.
  function automatic logic [CNT_BITS-1:0] sat_inc(
    input logic [CNT_BITS-1:0] cnt,
    input logic                inc
  );
    if (inc && (cnt != CNT_MAX)) begin
      return cnt + CNT_BITS'(1);
    end
    return cnt;
  endfunction

  det_state_t          state_q, state_d;
  logic                solid_q, solid_d;
  logic                jump_q, jump_d;
  edge_code_t          edge_q, edge_d;
  logic [CNT_BITS-1:0] solid_cnt_q, solid_cnt_d;
  logic [CNT_BITS-1:0] jump_cnt_q, jump_cnt_d;
  edge_code_t          acc_edge_q, acc_edge_d;
  logic                col_q, col_d;
  logic                jcol_q, jcol_d;
  edge_code_t          code_q, code_d;

  edge_code_t          pix_edge;
  logic                hit_solid, hit_jump;
  logic [CNT_BITS-1:0] solid_cnt_nx, jump_cnt_nx;
  edge_code_t          acc_edge_nx;
  logic                col_nx;

  edge_classifier #(
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .EDGE_BAND (EDGE_BAND)
  ) u_edge (
    .offX_i (bus.bumpyOffsetX),
    .offY_i (bus.bumpyOffsetY),
    .edge_o (pix_edge)
  );

  // Stage 1 inputs: overlap tests for the pixel on the bus this clock
  assign hit_solid = bus.bumpyDR & (bus.brickDR | bus.borderDR);
  assign hit_jump  = bus.bumpyDR & bus.jumpBrickDR;

  // Stage 2 inputs: frame totals including the pixel held in stage 1, which
  // still belongs to the frame that a coincident startOfFrame closes
  assign solid_cnt_nx = sat_inc(solid_cnt_q, solid_q | jump_q);
  assign jump_cnt_nx  = sat_inc(jump_cnt_q, jump_q);
  assign acc_edge_nx  = acc_edge_q | edge_q;
  assign col_nx       = (solid_cnt_nx >= CNT_THR);

  // Next-state, pipeline, accumulator and publish logic
  always_comb begin
    state_d     = state_q;
    solid_d     = hit_solid;
    jump_d      = hit_jump;
    edge_d      = (hit_solid | hit_jump) ? pix_edge : '0;
    solid_cnt_d = solid_cnt_nx;
    jump_cnt_d  = jump_cnt_nx;
    acc_edge_d  = acc_edge_nx;
    col_d       = col_q;
    jcol_d      = jcol_q;
    code_d      = code_q;

    if (bus.EndGame) begin
      state_d     = ST_CLEAR;
      solid_d     = 1'b0;
      jump_d      = 1'b0;
      edge_d      = '0;
      solid_cnt_d = '0;
      jump_cnt_d  = '0;
      acc_edge_d  = '0;
      col_d       = 1'b0;
      jcol_d      = 1'b0;
      code_d      = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.startOfFrame) begin
            col_d       = col_nx;
            jcol_d      = (jump_cnt_nx >= CNT_THR);
            code_d      = col_nx ? acc_edge_nx : '0;
            solid_cnt_d = '0;
            jump_cnt_d  = '0;
            acc_edge_d  = '0;
          end
        end
        ST_CLEAR: begin
          // The partial frame after EndGame is dropped; the pixel on the
          // reopening startOfFrame clock is the first one of the new frame.
          solid_cnt_d = '0;
          jump_cnt_d  = '0;
          acc_edge_d  = '0;
          col_d       = 1'b0;
          jcol_d      = 1'b0;
          code_d      = '0;
          if (bus.startOfFrame) begin
            state_d = ST_RUN;
          end else begin
            solid_d = 1'b0;
            jump_d  = 1'b0;
            edge_d  = '0;
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  // State, stage-1 pipeline, stage-2 accumulators and published outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_RUN;
      solid_q     <= 1'b0;
      jump_q      <= 1'b0;
      edge_q      <= '0;
      solid_cnt_q <= '0;
      jump_cnt_q  <= '0;
      acc_edge_q  <= '0;
      col_q       <= 1'b0;
      jcol_q      <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      solid_q     <= solid_d;
      jump_q      <= jump_d;
      edge_q      <= edge_d;
      solid_cnt_q <= solid_cnt_d;
      jump_cnt_q  <= jump_cnt_d;
      acc_edge_q  <= acc_edge_d;
      col_q       <= col_d;
      jcol_q      <= jcol_d;
      code_q      <= code_d;
    end
  end

  assign bus.collision     = col_q;
  assign bus.jumpCollision = jcol_q;
  assign bus.HitEdgeCode   = code_q;

endmodule

// File: tb/tb_bumpy_collision_detect.sv
// Bench for bumpy_collision_detect: directed frames from the test plan plus
// randomized frames, all checked every clock against a frame-level model.
module tb_bumpy_collision_detect;
  import bumpy_pkg::*;

  localparam int MIN_HIT = 2;
  localparam int CNT_MAX = 1023;
  localparam int K_BRICK = 0;
  localparam int K_JUMP  = 1;
  localparam int K_BORD  = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  bumpy_collision_detect_if bus ();

  bumpy_collision_detect dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: integer overlap totals and an OR of touched edges
  int         m_cnt, m_jcnt;
  logic [3:0] m_edge;
  bit         m_discard;
  logic       exp_col, exp_jcol;
  logic [3:0] exp_code;

  function automatic logic [3:0] spec_edge(input int ox, input int oy);
    logic [3:0] e;
    e = 4'b0000;
    if (ox < 32 && oy < 32) begin
      e[EDGE_BOTTOM] = (oy >= 28);
      e[EDGE_RIGHT]  = (ox >= 28);
      e[EDGE_TOP]    = (oy < 4);
      e[EDGE_LEFT]   = (ox < 4);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_jcnt = 0; m_edge = 4'b0000;
    exp_col = 1'b0; exp_jcol = 1'b0; exp_code = 4'b0000;
  endtask

  task automatic model_add(input bit dr, input int ox, input int oy,
                           input bit br, input bit jb, input bit bd);
    bit hit;
    hit = dr && (br || bd || jb);
    if (hit) begin
      m_cnt  = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_edge = m_edge | spec_edge(ox, oy);
    end
    if (dr && jb) m_jcnt = (m_jcnt + 1 > CNT_MAX) ? CNT_MAX : m_jcnt + 1;
  endtask

  task automatic model_clock(input bit sof, input bit eg, input bit dr,
                             input int ox, input int oy,
                             input bit br, input bit jb, input bit bd);
    if (eg) begin
      model_clear();
      m_discard = 1'b1;
    end else if (sof) begin
      if (!m_discard) begin
        exp_col  = (m_cnt >= MIN_HIT);
        exp_jcol = (m_jcnt >= MIN_HIT);
        exp_code = exp_col ? m_edge : 4'b0000;
      end
      m_discard = 1'b0;
      m_cnt = 0; m_jcnt = 0; m_edge = 4'b0000;
      model_add(dr, ox, oy, br, jb, bd);
    end else if (!m_discard) begin
      model_add(dr, ox, oy, br, jb, bd);
    end
  endtask

  task automatic check_model();
    chk("collision", int'(bus.collision), int'(exp_col));
    chk("jumpCollision", int'(bus.jumpCollision), int'(exp_jcol));
    chk("HitEdgeCode", int'(bus.HitEdgeCode), int'(exp_code));
  endtask

  // One clock: drive, let the edge happen, update the model, compare
  task automatic step(input bit sof, input bit eg, input bit dr,
                      input int ox, input int oy,
                      input bit br, input bit jb, input bit bd);
    bus.startOfFrame = sof;
    bus.EndGame      = eg;
    bus.bumpyDR      = dr;
    bus.bumpyOffsetX = 11'(ox);
    bus.bumpyOffsetY = 11'(oy);
    bus.brickDR      = br;
    bus.jumpBrickDR  = jb;
    bus.borderDR     = bd;
    @(posedge clk);
    if (resetN) model_clock(sof, eg, dr, ox, oy, br, jb, bd);
    #1;
    check_model();
  endtask

  task automatic pix(input int n, input int ox, input int oy, input int kind);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b1, ox, oy, kind == K_BRICK, kind == K_JUMP, kind == K_BORD);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sof();
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string name, input logic c, input logic j, input logic [3:0] e);
    chk({name, "_col"}, int'(bus.collision), int'(c));
    chk({name, "_jcol"}, int'(bus.jumpCollision), int'(j));
    chk({name, "_code"}, int'(bus.HitEdgeCode), int'(e));
  endtask

  initial begin
    bus.startOfFrame = 1'b0; bus.EndGame = 1'b0; bus.bumpyDR = 1'b0;
    bus.bumpyOffsetX = '0; bus.bumpyOffsetY = '0;
    bus.brickDR = 1'b0; bus.jumpBrickDR = 1'b0; bus.borderDR = 1'b0;
    model_clear();
    m_discard = 1'b0;
    #1;
    lit("reset", 1'b0, 1'b0, 4'b0000);
    idle(2);
    resetN = 1'b1;
    sof();

    // Bottom edge hit, held across the following frame
    pix(5, 16, 30, K_BRICK);
    sof();
    lit("bottom", 1'b1, 1'b0, 4'b0001);
    idle(12);
    lit("bottom_hold", 1'b1, 1'b0, 4'b0001);
    sof();
    lit("empty_after_bottom", 1'b0, 1'b0, 4'b0000);

    // Noise threshold on the left edge
    pix(1, 0, 10, K_BRICK);
    idle(3);
    sof();
    lit("one_pixel", 1'b0, 1'b0, 4'b0000);
    pix(2, 0, 10, K_BRICK);
    idle(3);
    sof();
    lit("two_pixels", 1'b1, 1'b0, 4'b1000);

    // Top-right corner on a jump brick
    pix(3, 31, 0, K_JUMP);
    sof();
    lit("corner_jump", 1'b1, 1'b1, 4'b0110);

    // Last pixel of the frame immediately before startOfFrame
    pix(1, 16, 16, K_BORD);
    idle(4);
    pix(1, 16, 16, K_BORD);
    sof();
    lit("boundary", 1'b1, 1'b0, 4'b0000);
    sof();
    lit("boundary_next", 1'b0, 1'b0, 4'b0000);

    // EndGame overriding a frame boundary, then a discarded partial frame
    pix(3, 30, 16, K_BRICK);
    sof();
    lit("pre_endgame", 1'b1, 1'b0, 4'b0010);
    pix(10, 30, 16, K_BRICK);
    step(1'b1, 1'b1, 1'b1, 30, 16, 1'b1, 1'b0, 1'b0);
    lit("endgame_sof", 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 30, 16, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 30, 16, 1'b1, 1'b0, 1'b0);
    pix(4, 30, 16, K_BRICK);
    sof();
    lit("after_endgame_sof", 1'b0, 1'b0, 4'b0000);
    pix(2, 1, 16, K_BRICK);
    sof();
    lit("restart", 1'b1, 1'b0, 4'b1000);

    // Overlap far beyond full scale; a wrapping counter would land on zero
    pix(2048, 16, 16, K_JUMP);
    sof();
    lit("saturate", 1'b1, 1'b1, 4'b0000);

    // Asynchronous reset mid-frame
    pix(5, 16, 16, K_BRICK);
    #3;
    resetN = 1'b0;
    model_clear();
    m_discard = 1'b0;
    #1;
    lit("async_reset", 1'b0, 1'b0, 4'b0000);
    pix(3, 0, 0, K_BRICK);
    resetN = 1'b1;
    pix(2, 30, 16, K_BRICK);
    sof();
    lit("post_reset", 1'b1, 1'b0, 4'b0010);

    // Randomized frames, including out-of-range offsets and EndGame bursts
    for (int f = 0; f < 40; f++) begin
      int len, dens, eg_at;
      len   = $urandom_range(5, 60);
      dens  = $urandom_range(0, 3) * 5;
      eg_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int c = 0; c < len; c++) begin
        bit eg;
        eg = (eg_at >= 0) && (c >= eg_at) && (c < eg_at + 3);
        step(1'b0, eg, $urandom_range(0, 99) < dens,
             $urandom_range(0, 35), $urandom_range(0, 35),
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0);
      end
      step(1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31), $urandom_range(0, 31),
           1'b1, $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bumpy_collision_detect.md
Name: bumpy_collision_detect

Overview:
- Pixel-rate collision detector that produces the `collision`, `jumpCollision` and `HitEdgeCode` inputs consumed by the Bumpy movement controller.
- Watches Bumpy's sprite drawing request against the brick, jump-brick and border drawing requests during the raster scan of frame N. Accumulates overlap counts and touched edges for that frame.
- At `startOfFrame` it publishes a stable per-frame summary, held for the whole of frame N+1.
- Sits between the sprite/tile object units and the movement controller, inside the VGA top level.

Parameters:
- SPRITE_W, 32: Bumpy sprite width in pixels.
- SPRITE_H, 32: Bumpy sprite height in pixels.
- EDGE_BAND, 4: thickness in pixels of each edge band inside the sprite.
- MIN_HIT_PIXELS, 2: overlapping pixels per frame needed to declare a collision (noise filter).
- CNT_BITS, 10: width of the saturating overlap counters.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock pulse at start of each frame
- EndGame  in  1  level; forces a clear of all state while high
- bumpyDR  in  1  Bumpy sprite drawing request for the current pixel
- bumpyOffsetX  in  11  pixel X offset inside the sprite, 0..SPRITE_W-1
- bumpyOffsetY  in  11  pixel Y offset inside the sprite, 0..SPRITE_H-1
- brickDR  in  1  solid brick drawing request
- jumpBrickDR  in  1  jump-brick drawing request
- borderDR  in  1  screen-border drawing request; treated as solid brick
- collision  out  1  frame N had at least MIN_HIT_PIXELS solid or jump overlaps
- jumpCollision  out  1  frame N had at least MIN_HIT_PIXELS jump-brick overlaps
- HitEdgeCode  out  4  edges touched in frame N: [0] bottom, [1] right, [2] top, [3] left

Behaviour:
- Clock and reset: single clock `clk`. Reset `resetN` is asynchronous, active-low.
- Reset values: all outputs 0, all counters 0, accumulated edge code 0, pipeline register 0.
- Stage 1 (registered, one clock):
  - solidHit = bumpyDR & (brickDR | borderDR)
  - jumpHit = bumpyDR & jumpBrickDR
  - edge bits for this pixel:
    - bottom: offY >= SPRITE_H-EDGE_BAND
    - top: offY < EDGE_BAND
    - right: offX >= SPRITE_W-EDGE_BAND
    - left: offX < EDGE_BAND
  - Edge bits are forced to 0 when neither hit is set.
  - A corner pixel sets two bits.
  - A centre pixel sets no edge bit but still counts toward the hit count.
- Stage 2 (accumulate, every clock):
  - solidCnt += solidHit | jumpHit
  - jumpCnt += jumpHit
  - Both counters saturate at 2^CNT_BITS-1 and never wrap.
  - accEdge |= stage-1 edge bits.
- Publish, on a startOfFrame clock:
  - collision <= (solidCnt_next >= MIN_HIT_PIXELS)
  - jumpCollision <= (jumpCnt_next >= MIN_HIT_PIXELS)
  - HitEdgeCode <= accEdge_next if collision_next, else 0
  - `_next` means the value including the stage-1 pixel in flight on that clock. That pixel belongs to the frame being closed.
  - Counters and accEdge then clear to 0 on the same edge.
- Output latency: outputs change only on startOfFrame edges, or on EndGame. They are stable for a full frame, so the movement controller's one-shot sampling sees a steady level.
- FSM, 2 states:
  - RUN: normal accumulate and publish.
  - CLEAR: entered on EndGame=1.
    - Outputs, counters, accEdge and the pipeline are held at 0 while EndGame=1.
    - Exit to RUN on the first startOfFrame after EndGame falls. Accumulation restarts from that frame.
    - The partial frame after EndGame falls is discarded.
- Simultaneous EndGame and startOfFrame: EndGame wins; no publish.
- Offsets are ignored when bumpyDR=0. Offsets outside the sprite range set no edge bit (defensive).
- MIN_HIT_PIXELS=1 degenerates to a pure OR detector.
- Reset asserted mid-frame: immediate clear. First publish after release reflects only pixels seen after release.

Decomposition:
- Shared package `bumpy_pkg`:
  - edge index constants: EDGE_BOTTOM=0, EDGE_RIGHT=1, EDGE_TOP=2, EDGE_LEFT=3
  - typedef `edge_code_t` (logic [3:0])
  - TILE_WIDTH=80 and BUMPY_OFFSET=24, so the movement controller uses the same constants.
- One sub-module, `edge_classifier`: combinational offset-to-edge-bits mapping, parameterised by SPRITE_W, SPRITE_H and EDGE_BAND.
- Counters and the FSM live in the top module.

Test Plan:
- Bottom hit: 5 clocks with bumpyDR=1, brickDR=1, offY=30, offX=16, then startOfFrame. Next frame: collision=1, jumpCollision=0, HitEdgeCode=4'b0001, held until the following startOfFrame.
- Threshold: exactly 1 overlap pixel (offX=0, offY=10), then startOfFrame. collision=0, HitEdgeCode=0. Repeat with 2 such pixels: collision=1, HitEdgeCode=4'b1000.
- Corner plus jump brick: 3 pixels with jumpBrickDR=1 at offX=31, offY=0, then startOfFrame. collision=1, jumpCollision=1, HitEdgeCode=4'b0110.
- Boundary pixel at the frame edge: a single overlap pixel presented on the clock before startOfFrame, with one earlier pixel in the same frame. Both are counted in the closing frame: collision=1. The following frame with no hits publishes collision=0 and HitEdgeCode=0.
- EndGame mid-frame: 10 overlap pixels, then EndGame=1 for 3 clocks coinciding with startOfFrame. Outputs forced to 0. No publish until the first startOfFrame after EndGame falls, and the partial frame is discarded.
- Saturation and async reset: 2000 overlap pixels with CNT_BITS=10. Counter holds at 1023 and collision=1. resetN pulsed low mid-frame: all outputs 0 immediately, without waiting for a clock edge.
